// File: rtl/ac_table_walker.sv
// Aho-Corasick goto/failure table walker: one symbol per walk, goto table scanned linearly.
// Latency: match at goto entry i is visible i+2 cycles after accept; each failure hop costs GOTO_DEPTH+1.
module ac_table_walker #(
  parameter int SYM_W      = 4,
  parameter int STATE_W    = 8,
  parameter int GOTO_DEPTH = 32,
  localparam int NSTATES   = 1 << STATE_W,
  localparam int MAXD      = (GOTO_DEPTH > NSTATES) ? GOTO_DEPTH : NSTATES,
  localparam int AW        = $clog2(MAXD),
  localparam int DW        = 2 * STATE_W + SYM_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_initialize,
  input  logic               i_en,
  input  logic [SYM_W-1:0]   i_string,
  output logic               o_ready,
  input  logic               i_wr_en,
  input  logic [1:0]         i_wr_sel,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [DW-1:0]      i_wr_data,
  output logic [STATE_W-1:0] o_now_state_out,
  output logic               o_out_valid,
  output logic               o_en_match,
  output logic               o_fail_err
);

  localparam int IW = (GOTO_DEPTH > 1) ? $clog2(GOTO_DEPTH) : 1;

  typedef struct packed {
    logic               vld;
    logic [STATE_W-1:0] cur;
    logic [SYM_W-1:0]   chr;
    logic [STATE_W-1:0] nxt;
  } goto_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FAIL, S_DONE} fsm_t;

  fsm_t               r_state, w_state_nx;
  logic [SYM_W-1:0]   r_sym, w_sym_nx;
  logic [STATE_W-1:0] r_s, w_s_nx;
  logic [IW-1:0]      r_idx, w_idx_nx;
  logic [STATE_W-1:0] r_hop, w_hop_nx;
  logic [STATE_W-1:0] r_cur;
  logic               r_out_valid, r_en_match, r_fail_err;

  goto_t              r_goto [GOTO_DEPTH];
  logic [STATE_W-1:0] r_fail [NSTATES];
  logic               r_acc  [NSTATES];

  goto_t              w_ent;
  logic               w_hit, w_last, w_ready, w_done, w_abort;
  logic [STATE_W-1:0] w_next;
  logic               w_wr_ok, w_wr_goto, w_wr_fail, w_wr_acc;

  assign w_ent   = r_goto[r_idx];
  assign w_hit   = w_ent.vld && (w_ent.cur == r_s) && (w_ent.chr == r_sym);
  assign w_last  = (r_idx == IW'(GOTO_DEPTH - 1));
  assign w_ready = (r_state == S_IDLE) && !i_wr_en && !i_initialize;

  // Table writes only land while idle so a walk never sees a half-updated table.
  assign w_wr_ok   = i_wr_en && (r_state == S_IDLE);
  assign w_wr_goto = w_wr_ok && (i_wr_sel == 2'd0) && (32'(i_wr_addr) < GOTO_DEPTH);
  assign w_wr_fail = w_wr_ok && (i_wr_sel == 2'd1) && (32'(i_wr_addr) < NSTATES);
  assign w_wr_acc  = w_wr_ok && (i_wr_sel == 2'd2) && (32'(i_wr_addr) < NSTATES);

  always_comb begin
    w_state_nx = r_state;
    w_sym_nx   = r_sym;
    w_s_nx     = r_s;
    w_idx_nx   = r_idx;
    w_hop_nx   = r_hop;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    w_next     = '0;
    case (r_state)
      S_IDLE: begin
        if (i_en && w_ready) begin
          w_sym_nx   = i_string;
          w_s_nx     = r_cur;
          w_idx_nx   = '0;
          w_hop_nx   = '0;
          w_state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_next     = w_ent.nxt;
          w_done     = 1'b1;
          w_state_nx = S_DONE;
        end else if (w_last) begin
          if (r_s == '0) begin
            w_done     = 1'b1;
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_FAIL;
          end
        end else begin
          w_idx_nx = r_idx + IW'(1);
        end
      end
      S_FAIL: begin
        // The hop that would make the count reach 2^STATE_W aborts instead of scanning again.
        if (r_hop == '1) begin
          w_abort    = 1'b1;
          w_done     = 1'b1;
          w_state_nx = S_DONE;
        end else begin
          w_s_nx     = r_fail[r_s];
          w_idx_nx   = '0;
          w_hop_nx   = r_hop + STATE_W'(1);
          w_state_nx = S_SCAN;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (i_initialize) begin
      w_state_nx = S_IDLE;
      w_idx_nx   = '0;
      w_hop_nx   = '0;
      w_done     = 1'b0;
      w_abort    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sym       <= '0;
      r_s         <= '0;
      r_idx       <= '0;
      r_hop       <= '0;
      r_cur       <= '0;
      r_out_valid <= 1'b0;
      r_en_match  <= 1'b0;
      r_fail_err  <= 1'b0;
      for (int i = 0; i < GOTO_DEPTH; i++) r_goto[i] <= '0;
      for (int i = 0; i < NSTATES; i++) begin
        r_fail[i] <= '0;
        r_acc[i]  <= 1'b0;
      end
    end else begin
      r_state     <= w_state_nx;
      r_sym       <= w_sym_nx;
      r_s         <= w_s_nx;
      r_idx       <= w_idx_nx;
      r_hop       <= w_hop_nx;
      // Result registers load on entry to DONE so they are visible during the DONE cycle.
      r_out_valid <= w_done;
      r_en_match  <= w_done && r_acc[w_next];
      if (w_done)            r_cur <= w_next;
      else if (i_initialize) r_cur <= '0;
      if (w_abort) r_fail_err <= 1'b1;
      if (w_wr_goto) r_goto[i_wr_addr[IW-1:0]]     <= goto_t'(i_wr_data);
      if (w_wr_fail) r_fail[i_wr_addr[STATE_W-1:0]] <= i_wr_data[STATE_W-1:0];
      if (w_wr_acc)  r_acc[i_wr_addr[STATE_W-1:0]]  <= i_wr_data[0];
    end
  end

  assign o_ready         = w_ready;
  assign o_now_state_out = r_cur;
  assign o_out_valid     = r_out_valid;
  assign o_en_match      = r_en_match;
  assign o_fail_err      = r_fail_err;

endmodule

// File: tb/tb_ac_table_walker.sv
// Directed and randomized bench for ac_table_walker against a table-walk reference model.
module tb_ac_table_walker;

  localparam int GD = 32;
  localparam logic [3:0] SY_H = 4'd1, SY_E = 4'd2, SY_S = 4'd3, SY_R = 4'd4, SY_X = 4'd5;

  logic        clk = 1'b0;
  logic        rst, init, en, wr_en;
  logic [3:0]  str;
  logic [1:0]  sel;
  logic [7:0]  addr;
  logic [20:0] data;
  logic        ready, out_valid, en_match, fail_err;
  logic [7:0]  now;

  ac_table_walker dut (
    .i_clk(clk), .i_rst(rst), .i_initialize(init), .i_en(en), .i_string(str),
    .o_ready(ready), .i_wr_en(wr_en), .i_wr_sel(sel), .i_wr_addr(addr), .i_wr_data(data),
    .o_now_state_out(now), .o_out_valid(out_valid), .o_en_match(en_match), .o_fail_err(fail_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int last_lat;

  // Reference model: plain arrays describing the loaded tables and the walk position.
  logic       m_gv [GD];
  logic [7:0] m_gc [GD];
  logic [3:0] m_gs [GD];
  logic [7:0] m_gn [GD];
  logic [7:0] m_fail [256];
  logic       m_acc [256];
  logic [7:0] m_cur;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < GD; i++) begin
      m_gv[i] = 1'b0; m_gc[i] = '0; m_gs[i] = '0; m_gn[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      m_fail[i] = '0; m_acc[i] = 1'b0;
    end
    m_cur = '0;
    m_err = 1'b0;
  endtask

  // Walk one symbol: first matching goto entry wins, else follow failure links.
  task automatic model_step(input logic [3:0] sym, output logic [7:0] ns, output int lat,
                            output bit abort);
    logic [7:0] s;
    int hops, hit;
    bit done;
    s = m_cur; hops = 0; lat = 0; abort = 0; done = 0; ns = '0;
    while (!done) begin
      hit = -1;
      for (int i = 0; i < GD; i++)
        if (hit < 0 && m_gv[i] && m_gc[i] == s && m_gs[i] == sym) hit = i;
      if (hit >= 0) begin
        ns = m_gn[hit]; lat += hit + 2; done = 1;
      end else if (s == 0) begin
        ns = '0; lat += GD + 1; done = 1;
      end else begin
        hops++;
        lat += GD + 1;
        if (hops == 256) begin
          abort = 1; ns = '0; done = 1;
        end else begin
          s = m_fail[s];
        end
      end
    end
    m_cur = ns;
    if (abort) m_err = 1'b1;
  endtask

  function automatic logic [20:0] gd(input logic [7:0] c, input logic [3:0] ch, input logic [7:0] n);
    return {1'b1, c, ch, n};
  endfunction

  task automatic wr(input logic [1:0] s, input logic [7:0] a, input logic [20:0] d);
    @(negedge clk);
    wr_en = 1'b1; sel = s; addr = a; data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (s == 2'd0 && a < GD) begin
      m_gv[a] = d[20]; m_gc[a] = d[19:12]; m_gs[a] = d[11:8]; m_gn[a] = d[7:0];
    end else if (s == 2'd1) begin
      m_fail[a] = d[7:0];
    end else if (s == 2'd2) begin
      m_acc[a] = d[0];
    end
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!ready) chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  task automatic feed(input logic [3:0] sym);
    logic [7:0] exp_ns;
    int exp_lat;
    bit ab, seen;
    model_step(sym, exp_ns, exp_lat, ab);
    @(negedge clk);
    wait_ready();
    en = 1'b1; str = sym;
    @(posedge clk);
    #1 en = 1'b0;
    seen = 0; last_lat = 0;
    for (int c = 1; c <= 10000; c++) begin
      @(negedge clk);
      if (out_valid) begin
        last_lat = c; seen = 1;
        break;
      end
    end
    chk("out_valid_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("now_state", {24'd0, now}, {24'd0, exp_ns});
      chk("en_match", {31'd0, en_match}, {31'd0, m_acc[exp_ns]});
      chk("fail_err", {31'd0, fail_err}, {31'd0, m_err});
      if (!ab) chk("latency", last_lat, exp_lat);
    end
  endtask

  task automatic init_pulse();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    m_cur = '0;
    chk("init_now", {24'd0, now}, 32'd0);
    chk("init_ov", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic load_base();
    wr(2'd0, 8'd0, gd(8'd0, SY_H, 8'd1));
    wr(2'd0, 8'd1, gd(8'd1, SY_E, 8'd2));
    wr(2'd0, 8'd2, gd(8'd0, SY_S, 8'd3));
    wr(2'd0, 8'd3, gd(8'd3, SY_H, 8'd4));
    wr(2'd0, 8'd4, gd(8'd4, SY_E, 8'd5));
    wr(2'd1, 8'd4, 21'd1);
    wr(2'd1, 8'd5, 21'd2);
    wr(2'd2, 8'd2, 21'd1);
    wr(2'd2, 8'd5, 21'd1);
  endtask

  task automatic run_she(input string tag);
    feed(SY_S); chk({tag, "_s"}, {24'd0, now}, 32'd3);
    feed(SY_H); chk({tag, "_h"}, {24'd0, now}, 32'd4);
    feed(SY_E); chk({tag, "_e"}, {24'd0, now}, 32'd5);
    chk({tag, "_e_match"}, {31'd0, en_match}, 32'd1);
  endtask

  int ov_cnt;
  logic [3:0] pick [6];

  initial begin
    rst = 1'b1; init = 1'b0; en = 1'b0; str = '0;
    wr_en = 1'b0; sel = '0; addr = '0; data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_now", {24'd0, now}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_match", {31'd0, en_match}, 32'd0);
    chk("rst_ferr", {31'd0, fail_err}, 32'd0);

    load_base();
    run_she("base");

    feed(SY_R);
    chk("r_now", {24'd0, now}, 32'd0);
    chk("r_lat", last_lat, 2 * (GD + 1) + GD + 1);

    feed(SY_H);
    chk("h_lat", last_lat, 2);
    chk("h_now", {24'd0, now}, 32'd1);
    @(negedge clk);
    chk("h_ready_t3", {31'd0, ready}, 32'd1);
    chk("h_ov_pulse", {31'd0, out_valid}, 32'd0);
    chk("h_hold", {24'd0, now}, 32'd1);

    // Duplicate entry must lose to entry 0; sel=3 and out-of-range writes are dropped.
    wr(2'd0, 8'd5, gd(8'd0, SY_H, 8'd7));
    wr(2'd3, 8'd6, gd(8'd0, SY_X, 8'd10));
    wr(2'd0, 8'd40, gd(8'd0, SY_X, 8'd9));
    init_pulse();
    feed(SY_X);
    chk("dropped_x", {24'd0, now}, 32'd0);

    pick[0] = SY_H; pick[1] = SY_E; pick[2] = SY_S; pick[3] = SY_R; pick[4] = SY_X;
    for (int k = 0; k < 40; k++) begin
      pick[5] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) init_pulse();
      feed(pick[$urandom_range(0, 5)]);
    end

    // Failure self-loop on state 1 runs the hop counter out.
    init_pulse();
    wr(2'd1, 8'd1, 21'd1);
    feed(SY_H);
    feed(SY_X);
    chk("loop_now", {24'd0, now}, 32'd0);
    chk("loop_ferr", {31'd0, fail_err}, 32'd1);
    feed(SY_H);
    chk("loop_ferr_sticky", {31'd0, fail_err}, 32'd1);
    init_pulse();
    chk("loop_ferr_init", {31'd0, fail_err}, 32'd1);

    // INITIALIZE mid-scan with a write attempted while busy.
    feed(SY_S);
    @(negedge clk);
    wait_ready();
    en = 1'b1; str = SY_R;
    @(posedge clk);
    #1 en = 1'b0;
    ov_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
      if (c == 4) begin
        wr_en = 1'b1; sel = 2'd0; addr = 8'd2; data = gd(8'd0, SY_S, 8'd9);
      end
      if (c == 5) wr_en = 1'b0;
      if (c == 8) init = 1'b1;
      if (c == 9) init = 1'b0;
    end
    m_cur = '0;
    chk("init_scan_ov", ov_cnt, 0);
    chk("init_scan_now", {24'd0, now}, 32'd0);
    chk("init_scan_ready", {31'd0, ready}, 32'd1);
    run_she("rerun");

    // Reset mid-scan clears outputs, sticky error and all tables.
    @(negedge clk);
    wait_ready();
    en = 1'b1; str = SY_S;
    @(posedge clk);
    #1 en = 1'b0;
    ov_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        chk("rst_scan_now", {24'd0, now}, 32'd0);
        chk("rst_scan_ferr", {31'd0, fail_err}, 32'd0);
        chk("rst_scan_match", {31'd0, en_match}, 32'd0);
      end
    end
    model_clear();
    chk("rst_scan_ov", ov_cnt, 0);
    chk("rst_scan_ready", {31'd0, ready}, 32'd1);
    feed(SY_H);
    chk("rst_cleared_h", {24'd0, now}, 32'd0);
    chk("rst_cleared_lat", last_lat, GD + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
